sci_master: RTL and testbench
=============================

Name: sci_master

Overview:
- Single-outstanding initiator for the SCI register bus: sciaddr, sciwdata, scirmxdata, sciwstn, scird.
- Converts a valid/ready command interface into timed SCI write and read cycles, and returns read data on a response strobe.
- Sits between on-chip control logic or a test sequencer and any SCI register responder, replacing the JTAG-driven initiator in bench and system use.

Parameters:
- ADDR_W, 18, SCI address width.
- DATA_W, 8, SCI data width.
- SETUP_CYC, 1, cycles address/data are stable before strobe; legal range 1..15.
- STROBE_CYC, 2, cycles sciwstn low or scird high; legal range 1..15.
- HOLD_CYC, 1, cycles address/data are held after strobe release; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target SCI address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse, transaction complete.
- rsp_write  out  1  type of the completed transaction.
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high on a read.
- sciaddr  out  ADDR_W  SCI address.
- sciwdata  out  DATA_W  SCI write data.
- scirmxdata  in  DATA_W  SCI read-mux data from the responder, combinational on sciaddr.
- sciwstn  out  1  active-low write strobe; responders capture on its falling edge.
- scird  out  1  active-high read strobe.
- sci_active  out  1  high while a bus cycle is in progress (state != IDLE); usable as a responder enable.

Behaviour:
- Reset values, applied immediately and asynchronously:
  - state = IDLE, so cmd_ready = 1.
  - sciwstn = 1, scird = 0.
  - sciaddr = 0, sciwdata = 0.
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0.
  - sci_active = 0.
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter, 4 bits, is reloaded on each state entry.
- cmd_ready = (state == IDLE), combinational.
- Accept: cmd_valid & cmd_ready at a rising edge.
  - Register cmd_addr into sciaddr and cmd_wdata into sciwdata.
  - Latch cmd_write; go to SETUP with count SETUP_CYC.
  - While not ready, command inputs are ignored; the requester must hold them.
- SETUP: strobes inactive. After SETUP_CYC cycles, go to STROBE.
- STROBE: on a write, sciwstn = 0; on a read, scird = 1. Both are registered outputs, so they are glitch-free.
  - On a read, scirmxdata is sampled into rsp_rdata at the final STROBE edge.
  - After STROBE_CYC cycles, go to HOLD; strobes return inactive on entry.
- HOLD: sciaddr and sciwdata unchanged.
  - rsp_valid = 1 and rsp_write = latched type in the first HOLD cycle only.
  - On a write, rsp_rdata keeps its previous value.
  - After HOLD_CYC cycles, go to IDLE.
- Timing: with the accept edge ending cycle 0 and defaults 1/2/1:
  - SETUP is cycle 1 and STROBE is cycles 2–3.
  - rsp_valid and HOLD are cycle 4.
  - IDLE, with cmd_ready = 1, is cycle 5.
  - General form: next accept is possible SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles after the previous accept.
- sciwstn and scird are never active together. Neither is active in IDLE, SETUP or HOLD.
- sciaddr and sciwdata change only at accept. In IDLE they keep their last value, so the read mux does not toggle.
- Back-to-back: if cmd_valid is high in the IDLE cycle after HOLD, it is accepted at that edge, with no extra bubble.
- Reset mid-transaction:
  - Strobes deassert immediately and no rsp_valid is issued.
  - A write aborted after the sciwstn falling edge is already committed at the responder; this is acceptable.
- rsp_valid has no backpressure; the consumer must take it in that cycle.

Test Plan:
- Write, defaults: cmd addr=0x00004, wdata=0xA5 against a responder model with R0..R3 at 0x4–0x7.
  - sciwstn low exactly cycles 2–3; R0 = 0xA5.
  - rsp_valid = 1 with rsp_write = 1 in cycle 4; cmd_ready high in cycle 5.
- Read constants: reads of 0x00000..0x00003.
  - rsp_rdata = 0x12, 0x34, 0x56, 0x78 respectively.
  - scird high 2 cycles per read; sciwstn stays 1 throughout.
- Write/read-back: write 0x3C to 0x00007, then read 0x00007 back-to-back.
  - rsp_rdata = 0x3C.
  - Second accept occurs in the cycle cmd_ready returns, 5 cycles after the first.
- Busy hold: cmd_valid held high with changing cmd_addr during a transaction.
  - Only the value present at a cmd_ready cycle is used.
  - sciaddr never changes outside accept.
- Reset during STROBE of a read at 0x00005: assert rst in cycle 2.
  - scird = 0 and cmd_ready = 1 immediately; no rsp_valid.
  - The next command after release completes normally.
- Parameter sweep SETUP/STROBE/HOLD = 3/1/2: strobe width is 1 cycle, rsp_valid in cycle 5, cmd_ready in cycle 7.

Source files
------------

// File: rtl/sci_master.sv
// sci_master: single-outstanding initiator for the SCI register bus.
// A valid/ready command is turned into one timed SCI cycle (setup, strobe and
// hold phases). Completion is signalled with a one-cycle response strobe,
// which carries the read data for read commands.
//
// Ports:
//   clk, rst            clock (rising edge) and async active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_write           1 = write, 0 = read
//   cmd_addr/wdata      target address and write data
//   rsp_valid           one-cycle completion pulse (no backpressure)
//   rsp_write/rdata     completed transaction type and read data
//   sciaddr/sciwdata    SCI address and write data, change only at accept
//   scirmxdata          responder read mux, combinational on sciaddr
//   sciwstn             active-low write strobe
//   scird               active-high read strobe
//   sci_active          high while a bus cycle is in progress
module sci_master #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sciaddr,
  output logic [DATA_W-1:0] sciwdata,
  input  logic [DATA_W-1:0] scirmxdata,
  output logic              sciwstn,
  output logic              scird,
  output logic              sci_active
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);

  state_t     state;
  logic [3:0] cnt;
  logic       wr;
  logic       last;

  assign cmd_ready = (state == IDLE);
  // The counter is loaded with the phase length on entry, so the phase ends
  // in the cycle where it reads 1.
  assign last = (cnt == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr         <= 1'b0;
      sciaddr    <= '0;
      sciwdata   <= '0;
      sciwstn    <= 1'b1;
      scird      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      sci_active <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sciaddr    <= cmd_addr;
            sciwdata   <= cmd_wdata;
            wr         <= cmd_write;
            cnt        <= SETUP_LD;
            state      <= SETUP;
            sci_active <= 1'b1;
          end
        end
        SETUP: begin
          if (last) begin
            state   <= STROBE;
            cnt     <= STROBE_LD;
            sciwstn <= ~wr;
            scird   <= ~wr;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (last) begin
            // Read data is captured on the same edge that releases the strobe.
            state     <= HOLD;
            cnt       <= HOLD_LD;
            sciwstn   <= 1'b1;
            scird     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= wr;
            if (!wr) rsp_rdata <= scirmxdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (last) begin
            state      <= IDLE;
            sci_active <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_master.sv
// tb_sci_master: directed bench for sci_master. Two instances are used: one
// with default timing (1/2/1) and one with 3/1/2. Each has its own responder
// model: constants 0x12/0x34/0x56/0x78 at 0x0..0x3, registers R0..R3 at
// 0x4..0x7 written on the falling edge of sciwstn.
module tb_sci_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cmd_valid, cmd_write;
  logic [17:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        a_ready, a_rv, a_rw, a_wstn, a_rd, a_act;
  logic [7:0]  a_rdata, a_wdata, a_rmx;
  logic [17:0] a_addr;
  logic        b_ready, b_rv, b_rw, b_wstn, b_rd, b_act;
  logic [7:0]  b_rdata, b_wdata, b_rmx;
  logic [17:0] b_addr;
  logic [7:0]  ra [4];
  logic [7:0]  rb [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sci_master u_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(a_rv), .rsp_write(a_rw), .rsp_rdata(a_rdata),
    .sciaddr(a_addr), .sciwdata(a_wdata), .scirmxdata(a_rmx),
    .sciwstn(a_wstn), .scird(a_rd), .sci_active(a_act));

  sci_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(b_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_rv), .rsp_write(b_rw), .rsp_rdata(b_rdata),
    .sciaddr(b_addr), .sciwdata(b_wdata), .scirmxdata(b_rmx),
    .sciwstn(b_wstn), .scird(b_rd), .sci_active(b_act));

  // Responder models
  always @(negedge a_wstn)
    if (!rst && a_addr >= 18'd4 && a_addr <= 18'd7) ra[a_addr[1:0]] <= a_wdata;
  always @(negedge b_wstn)
    if (!rst && b_addr >= 18'd4 && b_addr <= 18'd7) rb[b_addr[1:0]] <= b_wdata;

  always_comb begin
    a_rmx = 8'hEE;
    case (a_addr)
      18'd0: a_rmx = 8'h12;
      18'd1: a_rmx = 8'h34;
      18'd2: a_rmx = 8'h56;
      18'd3: a_rmx = 8'h78;
      18'd4: a_rmx = ra[0];
      18'd5: a_rmx = ra[1];
      18'd6: a_rmx = ra[2];
      18'd7: a_rmx = ra[3];
      default: a_rmx = 8'hEE;
    endcase
  end

  always_comb begin
    b_rmx = 8'hEE;
    case (b_addr)
      18'd0: b_rmx = 8'h12;
      18'd1: b_rmx = 8'h34;
      18'd2: b_rmx = 8'h56;
      18'd3: b_rmx = 8'h78;
      18'd4: b_rmx = rb[0];
      18'd5: b_rmx = rb[1];
      18'd6: b_rmx = rb[2];
      18'd7: b_rmx = rb[3];
      default: b_rmx = 8'hEE;
    endcase
  end

  // Selected-instance view
  logic        m_ready, m_rv, m_rw, m_wstn, m_rd, m_act;
  logic [7:0]  m_rdata;
  logic [17:0] m_addr;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_rv    = sel ? b_rv    : a_rv;
  assign m_rw    = sel ? b_rw    : a_rw;
  assign m_wstn  = sel ? b_wstn  : a_wstn;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_act   = sel ? b_act   : a_act;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_addr  = sel ? b_addr  : a_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Waits (bounded) for cmd_ready at a falling edge and presents a command.
  task automatic present(input bit w, input logic [17:0] a, input logic [7:0] d,
                         output bit ok);
    int k;
    k = 0;
    while (m_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = (m_ready === 1'b1);
    if (!ok) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // One transaction; checks per-cycle strobe/valid/ready/active masks.
  task automatic txn(input bit w, input logic [17:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit busy, output int acc);
    int s, t, h, n;
    bit ok;
    logic [15:0] wm, rm, vm, ym, am, xm, ewm, erm, evm, eym, eam;
    logic [7:0] prev_rd;
    s = sel ? 3 : 1;
    t = sel ? 1 : 2;
    h = sel ? 2 : 1;
    n = s + t + h + 1;
    wm = '0; rm = '0; vm = '0; ym = '0; am = '0; xm = '0;
    ewm = '0; erm = '0; evm = '0; eym = '0; eam = '0;
    present(w, a, d, ok);
    acc = cyc;
    prev_rd = m_rdata;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (m_wstn === 1'b0)  wm[c] = 1'b1;
      if (m_rd   === 1'b1)  rm[c] = 1'b1;
      if (m_rv   === 1'b1)  vm[c] = 1'b1;
      if (m_ready === 1'b1) ym[c] = 1'b1;
      if (m_act  === 1'b1)  am[c] = 1'b1;
      if (m_addr !== a)     xm[c] = 1'b1;
      if (c > s && c <= s + t) begin
        if (w) ewm[c] = 1'b1;
        else   erm[c] = 1'b1;
      end
      if (c == s + t + 1) begin
        evm[c] = 1'b1;
        chk("rsp_write", m_rw, w);
        chk("rsp_rdata", m_rdata, w ? prev_rd : exp_rd);
      end
      if (c == n) eym[c] = 1'b1;
      else        eam[c] = 1'b1;
      if (busy && c < n) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = 18'($urandom);
        cmd_wdata = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("wstn_mask", wm, ewm);
    chk("rd_mask", rm, erm);
    chk("rv_mask", vm, evm);
    chk("ready_mask", ym, eym);
    chk("active_mask", am, eam);
    chk("addr_stable", xm, 0);
  endtask

  initial begin
    int acc1, acc2;
    bit ok;
    logic [15:0] vm;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'h00;
      rb[i] = 8'h00;
    end
    rst = 1'b1;
    sel = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_wstn", a_wstn, 1);
    chk("rst_rd", a_rd, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_rw", a_rw, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_active", a_act, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write with default timing, then constant reads
    txn(1'b1, 18'h00004, 8'hA5, 8'h00, 1'b0, acc1);
    chk("r0_written", ra[0], 8'hA5);
    txn(1'b0, 18'h00000, 8'h00, 8'h12, 1'b0, acc1);
    txn(1'b0, 18'h00001, 8'h00, 8'h34, 1'b0, acc1);
    txn(1'b0, 18'h00002, 8'h00, 8'h56, 1'b0, acc1);
    txn(1'b0, 18'h00003, 8'h00, 8'h78, 1'b0, acc1);

    // Back-to-back write / read-back
    txn(1'b1, 18'h00007, 8'h3C, 8'h00, 1'b0, acc1);
    txn(1'b0, 18'h00007, 8'h00, 8'h3C, 1'b0, acc2);
    chk("b2b_gap", acc2 - acc1, 5);

    // Busy hold: junk commands while busy, real command at the ready cycle
    txn(1'b1, 18'h00006, 8'h11, 8'h00, 1'b1, acc1);
    txn(1'b0, 18'h00006, 8'h00, 8'h11, 1'b0, acc2);
    chk("busy_gap", acc2 - acc1, 5);

    // Reset in the STROBE phase of a read
    present(1'b0, 18'h00005, 8'h00, ok);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd", a_rd, 1);
    rst = 1'b1;
    #1;
    chk("abort_rd", a_rd, 0);
    chk("abort_ready", a_ready, 1);
    chk("abort_active", a_act, 0);
    @(negedge clk);
    rst = 1'b0;
    vm = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_rv !== 1'b0) vm[c] = 1'b1;
    end
    chk("abort_no_rv", vm, 0);
    txn(1'b1, 18'h00005, 8'h66, 8'h00, 1'b0, acc1);
    txn(1'b0, 18'h00005, 8'h00, 8'h66, 1'b0, acc1);

    // 3/1/2 timing instance
    sel = 1'b1;
    @(negedge clk);
    txn(1'b1, 18'h00006, 8'h5A, 8'h00, 1'b0, acc1);
    chk("rb2_written", rb[2], 8'h5A);
    txn(1'b0, 18'h00006, 8'h00, 8'h5A, 1'b0, acc2);
    chk("sweep_gap", acc2 - acc1, 7);
    txn(1'b0, 18'h00002, 8'h00, 8'h56, 1'b0, acc1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
